// File: rtl/mc_core.sv
// Multicycle MIPS-subset core with req/ready memory handshakes, a trap state
// for illegal or misaligned operations, and a retired-instruction counter.
module mc_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          RF_DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        retired,
  output logic [31:0] instret,
  output logic        trap,
  output logic [31:0] pc_out
);
  localparam int         AW    = $clog2(RF_DEPTH);
  localparam logic [5:0] DEPTH = 6'(RF_DEPTH);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  state_t state, state_nx;

  logic [31:0] pc, ir, a, b, alu_out, mdr;
  logic [31:0] gpr [RF_DEPTH];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] simm, zimm, mem_addr, r_res;
  logic        is_addu, is_subu, is_sll, is_r, is_ori, is_lw, is_sw;
  logic        is_beq, is_bne, is_br, is_j, legal, rf_bad, taken, misaligned;
  logic [AW-1:0] wb_idx;
  logic [31:0]   wb_data;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign shamt = ir[10:6];
  assign funct = ir[5:0];
  assign simm  = {{16{ir[15]}}, ir[15:0]};
  assign zimm  = {16'h0, ir[15:0]};

  assign is_addu = (op == 6'h00) && (funct == 6'h21);
  assign is_subu = (op == 6'h00) && (funct == 6'h23);
  assign is_sll  = (op == 6'h00) && (funct == 6'h00);
  assign is_r    = is_addu | is_subu | is_sll;
  assign is_ori  = (op == 6'h0D);
  assign is_lw   = (op == 6'h23);
  assign is_sw   = (op == 6'h2B);
  assign is_beq  = (op == 6'h04);
  assign is_bne  = (op == 6'h05);
  assign is_br   = is_beq | is_bne;
  assign is_j    = (op == 6'h02);
  assign legal   = is_r | is_ori | is_lw | is_sw | is_br | is_j;

  // Only the register fields an instruction actually reads or writes are range-checked.
  assign rf_bad = (((is_r & ~is_sll) | is_ori | is_lw | is_sw | is_br) && ({1'b0, rs} >= DEPTH))
               || ((is_r | is_ori | is_lw | is_sw | is_br) && ({1'b0, rt} >= DEPTH))
               || (is_r && ({1'b0, rd} >= DEPTH));

  assign mem_addr   = a + simm;
  assign misaligned = |mem_addr[1:0];
  assign taken      = is_beq ? (a == b) : (a != b);

  always_comb begin
    r_res = b << shamt;
    if (is_addu)      r_res = a + b;
    else if (is_subu) r_res = a - b;
  end

  assign wb_idx  = is_r ? rd[AW-1:0] : rt[AW-1:0];
  assign wb_data = is_lw ? mdr : alu_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      FETCH:  if (imem_ready) state_nx = DECODE;
      DECODE: state_nx = (!legal || rf_bad) ? TRAP : EXEC;
      EXEC: begin
        if (is_r || is_ori)      state_nx = WB;
        else if (is_lw || is_sw) state_nx = misaligned ? TRAP : MEM;
        else                     state_nx = FETCH;
      end
      MEM:    if (dmem_ready) state_nx = is_lw ? WB : FETCH;
      WB:     state_nx = FETCH;
      default: state_nx = TRAP;
    endcase
  end

  // Outputs are gated by reset so nothing is requested while reset is held.
  assign imem_req   = reset && (state == FETCH);
  assign imem_addr  = pc;
  assign dmem_req   = reset && (state == MEM);
  assign dmem_we    = is_sw;
  assign dmem_addr  = alu_out;
  assign dmem_wdata = b;
  assign trap       = reset && (state == TRAP);
  assign pc_out     = pc;
  assign retired    = reset && ((state == WB)
                    || ((state == EXEC) && (is_br || is_j))
                    || ((state == MEM) && dmem_ready && is_sw));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      instret <= '0;
    end else begin
      case (state)
        FETCH: if (imem_ready) begin
          ir <= imem_rdata;
          pc <= pc + 32'd4;
        end
        DECODE: begin
          a       <= gpr[rs[AW-1:0]];
          b       <= gpr[rt[AW-1:0]];
          alu_out <= pc + (simm << 2);
        end
        EXEC: begin
          if (is_r)                 alu_out <= r_res;
          else if (is_ori)          alu_out <= a | zimm;
          else if (is_lw || is_sw)  alu_out <= mem_addr;
          else if (is_br && taken)  pc <= alu_out;
          else if (is_j)            pc <= {pc[31:28], ir[25:0], 2'b00};
        end
        MEM: if (dmem_ready && is_lw) mdr <= dmem_rdata;
        default: ;
      endcase
      if (retired) instret <= instret + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RF_DEPTH; i++) gpr[i] <= '0;
    end else if ((state == WB) && (wb_idx != '0)) begin
      gpr[wb_idx] <= wb_data;
    end
  end
endmodule

// File: doc/mc_core.md
# mc_core

Parametrised multicycle MIPS-subset core that succeeds the fixed-timing multicycle CPU top. It owns its own FSM, PC, IR, A/B, ALUOut and MDR registers and talks to instruction and data memories through req/ready handshakes, so memories may insert wait states. It adds `bne`, a configurable register-file depth and reset PC, a trap state for illegal or misaligned operations, and a retired-instruction counter. It sits between the board-level memories and the debug/LED logic.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- `RF_DEPTH`, 32, number of GPRs, 16 or 32; register 0 reads as 0.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `imem_req`  out  1  instruction fetch request, held until accepted.
- `imem_addr`  out  32  fetch address (= PC).
- `imem_ready`  in  1  fetch accepted and `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `dmem_req`  out  1  data access request, held until accepted.
- `dmem_we`  out  1  1 = store, 0 = load; valid while `dmem_req` is high.
- `dmem_addr`  out  32  data address (= ALUOut).
- `dmem_wdata`  out  32  store data (= B register).
- `dmem_ready`  in  1  access accepted, load data valid this cycle.
- `dmem_rdata`  in  32  load data.
- `retired`  out  1  one-cycle pulse per completed instruction.
- `instret`  out  32  retired-instruction count, wraps 0xFFFF_FFFF -> 0.
- `trap`  out  1  sticky: core halted in TRAP.
- `pc_out`  out  32  current PC.

## Operation
- Supported instructions: `addu` (op 0x00, funct 0x21), `subu` (0x00/0x23), `sll` (0x00/0x00), `ori` (0x0D, zero-extended imm), `lw` (0x23), `sw` (0x2B), `beq` (0x04), `bne` (0x05), `j` (0x02). Any other op/funct is illegal.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: `imem_req`=1, `imem_addr`=PC. Stay until `imem_ready`; on that edge IR<=`imem_rdata`, PC<=PC+4, go DECODE.
- DECODE: A<=GPR[rs], B<=GPR[rt], ALUOut<=PC+(sext(imm16)<<2). Illegal opcode/funct, or any used register index >= `RF_DEPTH` -> TRAP.
- EXEC:
  - R-type: ALUOut<=result -> WB. `sll` uses shamt IR[10:6] on B.
  - `ori`: ALUOut<=A|zext(imm) -> WB.
  - `lw`/`sw`: ALUOut<=A+sext(imm). Address[1:0]≠0 -> TRAP, no request issued. Otherwise -> MEM.
  - `beq`/`bne`: if taken, PC<=ALUOut (branch target). Retire -> FETCH.
  - `j`: PC<={PC[31:28], IR[25:0], 2'b00}. Retire -> FETCH.
- MEM: `dmem_req`=1, `dmem_we`=(`sw`). Stay until `dmem_ready`.
  - `lw`: MDR<=`dmem_rdata` -> WB.
  - `sw`: retire -> FETCH.
- WB: write ALUOut (R-type → rd, `ori` → rt) or MDR (`lw` → rt). Writes to register 0 are dropped. Retire -> FETCH.
- TRAP: no requests, `trap`=1, PC frozen. Only reset exits.
- Retire: `retired`=1 for exactly one cycle and `instret` increments on the same edge.
- All arithmetic is 32-bit modulo; no overflow exceptions.

## Timing
- Reset (`reset`=0, async): PC=`RESET_PC`, state=FETCH, IR/A/B/ALUOut/MDR=0, all GPRs=0, `instret`=0.
- While in reset, all request, `retired` and `trap` outputs are 0.
- First `imem_req` is asserted in the first cycle after `reset` rises.
- Cycle counts with zero-wait memory (ready in same cycle as req): R-type/`ori` 4, `lw` 5, `sw` 4, `beq`/`bne`/`j` 3. Each memory wait cycle adds 1.
- `req`, `addr`, `we` and `wdata` are stable from assertion until the ready cycle. Ready while req=0 is ignored.
- Reset asserted mid-handshake drops `req` immediately (asynchronous). The pending access is abandoned and nothing is written.
- `instret` wrap: at 0xFFFF_FFFF, the next retire gives 0 and `retired` still pulses.

## Test plan
- Zero-wait sequence `ori $1,$0,5`; `ori $2,$0,3`; `subu $3,$1,$2` -> $3=2, `instret`=3 after 12 cycles, three `retired` pulses.
- `sw $3,8($0)` then `lw $4,8($0)` with 2 wait states on each access -> store at addr 8 with data 2, `dmem_req` held 3 cycles per access, $4=2, `lw` takes 7 cycles.
- `beq $1,$1,-1` at PC 0x10 -> PC=0x10 again after 3 cycles. `bne $1,$1,-1` -> PC=0x14.
- `j 0x40` at PC 0x1000_0000 -> PC=0x1000_0100. Also write to $0 (`ori $0,$0,7`) -> $0 still reads 0.
- Illegal word 0xFC00_0000 -> `trap`=1 after DECODE, no further `imem_req`. `lw` to addr 0x6 -> TRAP with `dmem_req` never asserted. Deasserting and reasserting reset clears `trap`.
- `RF_DEPTH`=16 build: `addu $20,$1,$2` -> TRAP. Preload `instret` to 0xFFFF_FFFF via force, retire one instruction -> `instret`=0.
